// File: rtl/demux_pkg.sv
// Shared constants and the select decode for the registered 1-to-8 demultiplexer.
package demux_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NUM_LANES  = 8;
  localparam int SEL_W      = 3;

  function automatic logic [NUM_LANES-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/demux32_1to8_lane.sv
// One single-entry holding register: flush beats push, push beats pop.
module demux32_1to8_lane
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_d, full_q;
  logic [DATA_W-1:0] data_d, data_q;

  // NOTE: every output gets its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (push_i) begin
      // Covers a push and pop on the same lane: the new word replaces the departing one.
      full_d = 1'b1;
      data_d = data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of block order.
  // NOTE: the data register is reset too, so consumers never observe an undefined word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/demux32_1to8.sv
// Registered 1-to-8 demultiplexer: steers a tagged producer stream into eight handshaked lanes.
module demux32_1to8
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [SEL_W-1:0]     select_i,
  input  logic [DATA_W-1:0]    data_i,
  output logic [NUM_LANES-1:0] valid_o,
  input  logic [NUM_LANES-1:0] ready_i,
  output logic [DATA_W-1:0]    data0_o,
  output logic [DATA_W-1:0]    data1_o,
  output logic [DATA_W-1:0]    data2_o,
  output logic [DATA_W-1:0]    data3_o,
  output logic [DATA_W-1:0]    data4_o,
  output logic [DATA_W-1:0]    data5_o,
  output logic [DATA_W-1:0]    data6_o,
  output logic [DATA_W-1:0]    data7_o,
  output logic                 busy_o
);

  logic [NUM_LANES-1:0] full;
  logic [NUM_LANES-1:0] pop;
  logic [NUM_LANES-1:0] push_sel;
  logic                 push;
  logic [DATA_W-1:0]    lane_data [NUM_LANES];

  // Accept depends only on the target lane's state, never on valid_i.
  assign ready_o  = rst_n_i & ~flush_i & (~full[select_i] | ready_i[select_i]);
  assign push     = valid_i & ready_o;
  assign push_sel = push ? sel_onehot(select_i) : '0;
  assign pop      = full & ready_i;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    demux32_1to8_lane #(.DATA_W(DATA_W)) u_lane (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .flush_i (flush_i),
      .push_i  (push_sel[k]),
      .pop_i   (pop[k]),
      .data_i  (data_i),
      .full_o  (full[k]),
      .data_o  (lane_data[k])
    );
  end

  assign valid_o = full;
  assign busy_o  = |full;
  assign data0_o = lane_data[0];
  assign data1_o = lane_data[1];
  assign data2_o = lane_data[2];
  assign data3_o = lane_data[3];
  assign data4_o = lane_data[4];
  assign data5_o = lane_data[5];
  assign data6_o = lane_data[6];
  assign data7_o = lane_data[7];

endmodule

// File: tb/tb_demux32_1to8.sv
// Self-checking bench for demux32_1to8: directed vector table, hand sequences, random traffic vs a lane model.
module tb_demux32_1to8;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  select_i;
  logic [31:0] data_i;
  logic [7:0]  valid_o;
  logic [7:0]  ready_i;
  logic [31:0] data0_o, data1_o, data2_o, data3_o, data4_o, data5_o, data6_o, data7_o;
  logic        busy_o;
  logic [31:0] dout [8];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which lanes hold a word and what word each lane presents.
  logic [7:0]  m_full;
  logic [31:0] m_data [8];

  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic [31:0] d;
    logic [7:0]  rdy;
    logic        fl;
    logic        exp_ready;
    logic [7:0]  exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [15];

  demux32_1to8 #(.DATA_W(32)) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .select_i (select_i),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data0_o  (data0_o),
    .data1_o  (data1_o),
    .data2_o  (data2_o),
    .data3_o  (data3_o),
    .data4_o  (data4_o),
    .data5_o  (data5_o),
    .data6_o  (data6_o),
    .data7_o  (data7_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  assign dout[0] = data0_o;
  assign dout[1] = data1_o;
  assign dout[2] = data2_o;
  assign dout[3] = data3_o;
  assign dout[4] = data4_o;
  assign dout[5] = data5_o;
  assign dout[6] = data6_o;
  assign dout[7] = data7_o;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [2:0] sel, input logic [31:0] d,
                              input logic [7:0] rdy, input logic fl, input logic er,
                              input logic [7:0] ev, input logic [31:0] ed);
    vec_t r;
    r.v = v; r.sel = sel; r.d = d; r.rdy = rdy; r.fl = fl;
    r.exp_ready = er; r.exp_valid = ev; r.exp_data = ed;
    return r;
  endfunction

  task automatic model_reset();
    m_full = '0;
    for (int k = 0; k < 8; k++) m_data[k] = '0;
  endtask

  task automatic check_state(input string tag);
    check({tag, " valid_o"}, 64'(valid_o), 64'(m_full));
    check({tag, " busy_o"}, 64'(busy_o), 64'(m_full != 8'h00));
    for (int k = 0; k < 8; k++)
      check($sformatf("%s data%0d_o", tag, k), 64'(dout[k]), 64'(m_data[k]));
  endtask

  // One clock of traffic: drive at the falling edge, check ready_o, then check state after the rising edge.
  task automatic step(input logic v, input logic [2:0] s, input logic [31:0] d,
                      input logic [7:0] r, input logic f, output logic rdy_seen);
    logic exp_rdy;
    @(negedge clk_i);
    valid_i = v; select_i = s; data_i = d; ready_i = r; flush_i = f;
    #1;
    exp_rdy  = !f && (!m_full[s] || r[s]);
    rdy_seen = ready_o;
    check("ready_o", 64'(ready_o), 64'(exp_rdy));
    @(posedge clk_i);
    if (f) begin
      m_full = '0;
    end else begin
      m_full = m_full & ~r;
      if (v && exp_rdy) begin
        m_full[s] = 1'b1;
        m_data[s] = d;
      end
    end
    #1;
    check_state("step");
  endtask

  initial begin
    logic       rdy;
    logic [7:0] rmask;

    rst_n_i = 1'b0; flush_i = 1'b0; valid_i = 1'b1; select_i = 3'd0;
    data_i = 32'h1234_5678; ready_i = 8'h00;
    model_reset();

    // Reset held for three cycles with a word on offer.
    repeat (3) @(negedge clk_i);
    #1;
    check("reset ready_o", 64'(ready_o), 64'd0);
    check("reset valid_o", 64'(valid_o), 64'h00);
    check("reset busy_o", 64'(busy_o), 64'd0);
    for (int k = 0; k < 8; k++) check($sformatf("reset data%0d_o", k), 64'(dout[k]), 64'd0);
    rst_n_i = 1'b1;
    #1;
    check("post-reset ready_o", 64'(ready_o), 64'd1);
    check("post-reset busy_o", 64'(busy_o), 64'd0);
    valid_i = 1'b0;

    // Directed vectors; each row expects the state left by the rows before it.
    tbl[0]  = mk(1'b1, 3'd5, 32'hDEADBEEF, 8'h00, 1'b0, 1'b1, 8'h20, 32'hDEADBEEF);
    tbl[1]  = mk(1'b0, 3'd5, 32'h0,        8'h20, 1'b0, 1'b1, 8'h00, 32'hDEADBEEF);
    tbl[2]  = mk(1'b1, 3'd2, 32'hAA,       8'h00, 1'b0, 1'b1, 8'h04, 32'hAA);
    tbl[3]  = mk(1'b1, 3'd2, 32'h11,       8'h00, 1'b0, 1'b0, 8'h04, 32'hAA);
    tbl[4]  = mk(1'b1, 3'd2, 32'h11,       8'h00, 1'b0, 1'b0, 8'h04, 32'hAA);
    tbl[5]  = mk(1'b1, 3'd2, 32'h11,       8'h00, 1'b0, 1'b0, 8'h04, 32'hAA);
    tbl[6]  = mk(1'b1, 3'd2, 32'h11,       8'h00, 1'b0, 1'b0, 8'h04, 32'hAA);
    tbl[7]  = mk(1'b1, 3'd2, 32'h11,       8'h04, 1'b0, 1'b1, 8'h04, 32'h11);
    tbl[8]  = mk(1'b1, 3'd7, 32'd1,        8'hFF, 1'b0, 1'b1, 8'h80, 32'd1);
    tbl[9]  = mk(1'b1, 3'd7, 32'd2,        8'hFF, 1'b0, 1'b1, 8'h80, 32'd2);
    tbl[10] = mk(1'b1, 3'd7, 32'd3,        8'hFF, 1'b0, 1'b1, 8'h80, 32'd3);
    tbl[11] = mk(1'b1, 3'd7, 32'd4,        8'hFF, 1'b0, 1'b1, 8'h80, 32'd4);
    tbl[12] = mk(1'b1, 3'd1, 32'h31,       8'h00, 1'b0, 1'b1, 8'h82, 32'h31);
    tbl[13] = mk(1'b1, 3'd3, 32'h33,       8'h00, 1'b0, 1'b1, 8'h8A, 32'h33);
    tbl[14] = mk(1'b1, 3'd4, 32'h44,       8'h00, 1'b1, 1'b0, 8'h00, 32'h0);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].rdy, tbl[i].fl, rdy);
      check($sformatf("vec%0d ready_o", i), 64'(rdy), 64'(tbl[i].exp_ready));
      check($sformatf("vec%0d valid_o", i), 64'(valid_o), 64'(tbl[i].exp_valid));
      check($sformatf("vec%0d lane data", i), 64'(dout[tbl[i].sel]), 64'(tbl[i].exp_data));
    end

    // Parallel lanes: fill all eight, then drain the 8'hA5 subset in one cycle.
    for (int k = 0; k < 8; k++) step(1'b1, 3'(k), 32'(k + 100), 8'h00, 1'b0, rdy);
    check("fill valid_o", 64'(valid_o), 64'hFF);
    step(1'b0, 3'd0, 32'h0, 8'hA5, 1'b0, rdy);
    check("parallel valid_o", 64'(valid_o), 64'h5A);
    for (int k = 0; k < 8; k++)
      check($sformatf("parallel data%0d_o", k), 64'(dout[k]), 64'(k + 100));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rmask = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom,
           8'($urandom) & rmask, ($urandom_range(0, 19) == 0), rdy);
    end

    // Reset asserted mid-cycle with lanes occupied clears state immediately.
    step(1'b1, 3'd6, 32'hCAFE_F00D, 8'h00, 1'b0, rdy);
    @(negedge clk_i);
    valid_i = 1'b1; select_i = 3'd6; ready_i = 8'h00; flush_i = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    model_reset();
    check("async reset ready_o", 64'(ready_o), 64'd0);
    check_state("async reset");
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step(1'b1, 3'd0, 32'h5, 8'h00, 1'b0, rdy);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
